spec_carry_fix: RTL and testbench
=================================

# spec_carry_fix

Block-serial error-correction stage placed directly downstream of the chain of speculative 4-bit sum blocks in the approximate adder. It takes the operands, the approximate sum and the carry-in each segment actually used, re-derives the exact inter-segment carries one segment per cycle, and patches every mis-speculated segment. The result is the exact sum plus error statistics, behind a valid/ready handshake.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of BLK; WIDTH/BLK ≥ 2
- BLK, 4, segment width (matches sum block width)
- NBLK, WIDTH/BLK, number of segments (derived; not overridden)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operand set present
- in_ready  out  1  stage can accept; high only in IDLE
- a, b  in  WIDTH  original operands
- s_apx  in  WIDTH  approximate sum from the sum block chain
- c_spec  in  NBLK  carry-in used by each segment; c_spec[0] is the true adder carry-in
- out_valid  out  1  result held
- out_ready  in  1  downstream accepts
- sum  out  WIDTH  exact sum
- cout  out  1  exact carry-out of the top segment
- corrected  out  1  at least one segment patched
- nfix  out  clog2(NBLK)+1  number of segments patched

## Operation
- FSM states: IDLE, SCAN, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid: register a, b, s_apx, c_spec; set c_ex=c_spec[0], k=1, nfix=0; → SCAN.
- SCAN, per cycle for segment k:
  - c_next = carry-out of a[k-1 seg] + b[k-1 seg] + c_ex, computed on BLK bits.
  - If c_next ≠ c_spec[k]: sum segment k += 1 (c_next=1) or −= 1 (c_next=0), modulo 2^BLK; nfix += 1. No carry/borrow leaves the segment; it is recovered when segment k+1 is scanned.
  - c_ex ← c_next; k ← k+1.
  - After k=NBLK−1: cout ← carry-out of top segment using exact carry-in; → DONE.
- DONE: out_valid=1; sum, cout, corrected (=nfix≠0), nfix stable. On out_ready: → IDLE.
- Segment 0 is never patched (c_spec[0] is exact by definition).
- c_spec[k] = 1 with exact carry 0 is legal (over-speculation) and produces a decrement.

## Timing
- Reset values: out_valid=0, sum=0, cout=0, corrected=0, nfix=0; in_ready=1 in the cycle after reset.
- Fixed latency: out_valid rises NBLK cycles after the accept edge (4 for defaults).
- in_ready is a pure decode of state==IDLE; no input accepted in SCAN or DONE.
- out_valid held with all outputs stable until out_ready sampled high; returns to IDLE on that edge, so next accept is earliest one cycle later (throughput 1 per NBLK+1 cycles).
- Inputs changing while not in IDLE are ignored.
- rst in any state: next edge → IDLE, all outputs to reset values, partial work discarded.

## Configuration
- APX_CARRY_FIX_EN defined: behaviour as above.
- Not defined: SCAN omitted; accept → DONE directly (latency 1), sum=s_apx, cout = carry-out of top segment computed with c_spec[NBLK−1], corrected=0, nfix=0. Handshake and reset behaviour unchanged.

## Test plan
- a=16'h00FF, b=16'h0001, c_spec=4'b0000, s_apx=16'h00F0 -> sum=16'h0100, cout=0, corrected=1, nfix=2, out_valid 4 cycles after accept.
- a=16'h0000, b=16'h0000, c_spec=4'b0010, s_apx=16'h0010 -> sum=16'h0000 (decrement path), cout=0, nfix=1.
- a=16'h1234, b=16'h1111, c_spec=0, s_apx=16'h2345 -> sum=16'h2345, corrected=0, nfix=0.
- a=16'hFFFF, b=16'h0001, c_spec=0, s_apx=16'hFFF0 -> sum=16'h0000, cout=1, nfix=3.
- out_ready low 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; rst asserted in SCAN -> next cycle IDLE, out_valid=0, sum=0.
- Macro undefined, first vector -> sum=16'h00F0, corrected=0, out_valid 1 cycle after accept.

Source files
------------

// File: rtl/spec_carry_fix.sv
// spec_carry_fix: serial carry-repair stage behind the speculative 4-bit sum-block chain.
// It takes the operands, the approximate sum and the carry-in each segment speculated.
// It rebuilds the exact inter-segment carries one segment per cycle and patches each
// mis-speculated segment by +1/-1.
// Optional feature macro: APX_CARRY_FIX_EN
//   defined   : accept -> SCAN (segments 1..NBLK-1, one per cycle) -> DONE.
//               out_valid is seen in the NBLK-th cycle after the accept cycle.
//   undefined : accept -> DONE directly. sum = s_apx, and cout is the top segment's
//               carry-out using c_spec[NBLK-1]. corrected and nfix stay 0.
module spec_carry_fix #(
    parameter  int WIDTH = 16,
    parameter  int BLK   = 4,
    localparam int NBLK  = WIDTH / BLK,
    localparam int NFW   = $clog2(NBLK) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] s_apx,
    input  logic [NBLK-1:0]  c_spec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             corrected,
    output logic [NFW-1:0]   nfix
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic [NFW-1:0]   nfix_q, nfix_d;

`ifdef APX_CARRY_FIX_EN
    localparam int KW = $clog2(NBLK);
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'((1 << BLK) - 1);

    // Captured operand set and scan progress
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [NBLK-1:0]  cspec_q, cspec_d;
    logic             cex_q, cex_d;     // exact carry into segment k-1
    logic [KW-1:0]    k_q, k_d;         // segment currently being repaired

    // Per-cycle scan datapath
    logic [KW-1:0]    km1;
    int               lo_sh, hi_sh;
    logic [BLK-1:0]   a_seg, b_seg, s_seg, s_fix;
    logic [BLK:0]     seg_res, top_res;
    logic [NBLK-1:0]  cspec_sh;
    logic             c_next, spec_k;
    logic [WIDTH-1:0] sum_fix;

    // Exact carry out of segment k-1, the +/-1 patch for segment k, and the top carry-out
    always_comb begin
        km1      = k_q - KW'(1);
        lo_sh    = int'(km1) * BLK;
        hi_sh    = int'(k_q) * BLK;
        a_seg    = BLK'(a_q >> lo_sh);
        b_seg    = BLK'(b_q >> lo_sh);
        s_seg    = BLK'(sum_q >> hi_sh);
        seg_res  = {1'b0, a_seg} + {1'b0, b_seg} + {{BLK{1'b0}}, cex_q};
        c_next   = seg_res[BLK];
        cspec_sh = cspec_q >> k_q;
        spec_k   = cspec_sh[0];
        // The patch never propagates: segment k+1 picks up the real carry when scanned.
        s_fix    = c_next ? (s_seg + BLK'(1)) : (s_seg - BLK'(1));
        sum_fix  = (sum_q & ~(SEG_MASK << hi_sh)) | (WIDTH'(s_fix) << hi_sh);
        // Only meaningful on the last step, where c_next is the exact carry into the top segment.
        top_res  = {1'b0, a_q[WIDTH-1 -: BLK]} + {1'b0, b_q[WIDTH-1 -: BLK]}
                 + {{BLK{1'b0}}, c_next};
    end
`else
    // Without repair only the top segment's carry-out is needed, and it uses the speculated carry.
    logic [BLK:0] top_in;
    logic         unused_lo;

    assign top_in    = {1'b0, a[WIDTH-1 -: BLK]} + {1'b0, b[WIDTH-1 -: BLK]}
                     + {{BLK{1'b0}}, c_spec[NBLK-1]};
    assign unused_lo = ^{a[WIDTH-BLK-1:0], b[WIDTH-BLK-1:0], c_spec[NBLK-2:0]};
`endif

    // Next-state and result-register updates for the accept / scan / hold sequence
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        nfix_d  = nfix_q;
`ifdef APX_CARRY_FIX_EN
        a_d     = a_q;
        b_d     = b_q;
        cspec_d = cspec_q;
        cex_d   = cex_q;
        k_d     = k_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sum_d  = s_apx;
                    nfix_d = '0;
`ifdef APX_CARRY_FIX_EN
                    a_d     = a;
                    b_d     = b;
                    cspec_d = c_spec;
                    cex_d   = c_spec[0];
                    k_d     = KW'(1);
                    cout_d  = 1'b0;
                    state_d = SCAN;
`else
                    cout_d  = top_in[BLK];
                    state_d = DONE;
`endif
                end
            end
            SCAN: begin
`ifdef APX_CARRY_FIX_EN
                if (c_next != spec_k) begin
                    sum_d  = sum_fix;
                    nfix_d = nfix_q + NFW'(1);
                end
                cex_d = c_next;
                k_d   = k_q + KW'(1);
                if (k_q == KW'(NBLK - 1)) begin
                    cout_d  = top_res[BLK];
                    state_d = DONE;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous reset that discards any partial work
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            nfix_q  <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            nfix_q  <= nfix_d;
        end
    end

`ifdef APX_CARRY_FIX_EN
    // Captured operands and scan progress
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            cspec_q <= '0;
            cex_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            cspec_q <= cspec_d;
            cex_q   <= cex_d;
            k_q     <= k_d;
        end
    end
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign nfix      = nfix_q;
    assign corrected = (nfix_q != '0);

endmodule

// File: tb/tb_spec_carry_fix.sv
// Testbench for spec_carry_fix.
// The reference model works on whole numbers. With repair enabled, the exact sum is a+b+c_spec[0].
// nfix counts the segment boundaries where the true prefix carry differs from c_spec.
module tb_spec_carry_fix;
    localparam int WIDTH = 16;
    localparam int BLK   = 4;
    localparam int NBLK  = WIDTH / BLK;
    localparam int NFW   = $clog2(NBLK) + 1;
`ifdef APX_CARRY_FIX_EN
    localparam int EXP_LAT = NBLK;
`else
    localparam int EXP_LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [WIDTH-1:0] s_apx = '0;
    logic [NBLK-1:0]  c_spec = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             corrected;
    logic [NFW-1:0]   nfix;

    int n_vec = 0;
    int n_err = 0;

    spec_carry_fix #(.WIDTH(WIDTH), .BLK(BLK)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .s_apx(s_apx), .c_spec(c_spec),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .corrected(corrected), .nfix(nfix)
    );

    always #5 clk = ~clk;

    // Behavioural reference: the result of the whole transaction from the arithmetic rules
    function automatic void ref_model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                                      input logic [WIDTH-1:0] ts, input logic [NBLK-1:0] tc,
                                      output logic [WIDTH-1:0] es, output logic ec,
                                      output logic [NFW-1:0] en);
`ifdef APX_CARRY_FIX_EN
        longint unsigned full, part, m;
        int cnt;
        full = longint'(ta) + longint'(tb_) + longint'(tc[0]);
        es   = full[WIDTH-1:0];
        ec   = full[WIDTH];
        cnt  = 0;
        for (int k = 1; k < NBLK; k++) begin
            m    = 64'd1 << (k * BLK);
            part = (longint'(ta) % m) + (longint'(tb_) % m) + longint'(tc[0]);
            if (((part >> (k * BLK)) & 64'd1) != longint'(tc[k])) cnt++;
        end
        en = NFW'(cnt);
        if (ts === 'x) en = 'x;
`else
        int t;
        t  = int'(ta >> (WIDTH - BLK)) + int'(tb_ >> (WIDTH - BLK)) + int'(tc[NBLK-1]);
        es = ts;
        ec = t[BLK];
        en = '0;
`endif
    endfunction

    // What the speculative sum-block chain produces for a given set of carry guesses
    function automatic logic [WIDTH-1:0] spec_sum(input logic [WIDTH-1:0] ta,
                                                  input logic [WIDTH-1:0] tb_,
                                                  input logic [NBLK-1:0] tc);
        logic [WIDTH-1:0] r;
        int sg;
        r = '0;
        for (int k = 0; k < NBLK; k++) begin
            sg = int'(ta[k*BLK +: BLK]) + int'(tb_[k*BLK +: BLK]) + int'(tc[k]);
            r[k*BLK +: BLK] = sg[BLK-1:0];
        end
        return r;
    endfunction

    // Present one operand set, then wait for out_valid (bounded) while scribbling the inputs
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic [WIDTH-1:0] ts, input logic [NBLK-1:0] tc, output int lat);
        a = ta; b = tb_; s_apx = ts; c_spec = tc;
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom);
        s_apx = WIDTH'($urandom); c_spec = NBLK'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        n_vec++; if (sum !== '0) begin n_err++; $display("FAIL rst_sum: got %h expected 0000", sum); end
        n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL rst_cout: got %b expected 0", cout); end
        n_vec++; if (corrected !== 1'b0) begin n_err++; $display("FAIL rst_corrected: got %b expected 0", corrected); end
        n_vec++; if (nfix !== '0) begin n_err++; $display("FAIL rst_nfix: got %0d expected 0", nfix); end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [4];
        logic [WIDTH-1:0] vb [4];
        logic [WIDTH-1:0] vs [4];
        logic [NBLK-1:0]  vc [4];
        logic [WIDTH-1:0] es;
        logic ec;
        logic [NFW-1:0] en;
        int lat;
        va[0] = 16'h00FF; vb[0] = 16'h0001; vs[0] = 16'h00F0; vc[0] = 4'b0000;
        va[1] = 16'h0000; vb[1] = 16'h0000; vs[1] = 16'h0010; vc[1] = 4'b0010;
        va[2] = 16'h1234; vb[2] = 16'h1111; vs[2] = 16'h2345; vc[2] = 4'b0000;
        va[3] = 16'hFFFF; vb[3] = 16'h0001; vs[3] = 16'hFFF0; vc[3] = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir_in_ready[%0d]: got %b expected 1", i, in_ready); end
            ref_model(va[i], vb[i], vs[i], vc[i], es, ec, en);
            send(va[i], vb[i], vs[i], vc[i], lat);
            n_vec++; if (lat != EXP_LAT) begin n_err++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, EXP_LAT); end
            n_vec++; if (sum !== es) begin n_err++; $display("FAIL dir_sum[%0d]: got %h expected %h", i, sum, es); end
            n_vec++; if (cout !== ec) begin n_err++; $display("FAIL dir_cout[%0d]: got %b expected %b", i, cout, ec); end
            n_vec++; if (nfix !== en) begin n_err++; $display("FAIL dir_nfix[%0d]: got %0d expected %0d", i, nfix, en); end
            n_vec++; if (corrected !== (en != 0)) begin n_err++; $display("FAIL dir_corrected[%0d]: got %b expected %b", i, corrected, en != 0); end
            release_out();
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir_release[%0d]: got %b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] ta, tb_, ts, es;
        logic [NBLK-1:0] tc;
        logic ec;
        logic [NFW-1:0] en;
        int lat;
        ta = 16'h0FFF; tb_ = 16'h0001; tc = 4'b0000;
        ts = spec_sum(ta, tb_, tc);
        ref_model(ta, tb_, ts, tc, es, ec, en);
        send(ta, tb_, ts, tc, lat);
        n_vec++; if (lat != EXP_LAT) begin n_err++; $display("FAIL stall_latency: got %0d expected %0d", lat, EXP_LAT); end
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            s_apx = WIDTH'($urandom); c_spec = NBLK'($urandom);
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, out_valid); end
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
            n_vec++; if (sum !== es) begin n_err++; $display("FAIL stall_sum[%0d]: got %h expected %h", i, sum, es); end
            n_vec++; if (cout !== ec || nfix !== en) begin n_err++; $display("FAIL stall_flags[%0d]: got cout=%b nfix=%0d expected cout=%b nfix=%0d", i, cout, nfix, ec, en); end
        end
        in_valid = 1'b0;
        release_out();
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL stall_exit: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL stall_no_phantom: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
    endtask

    task automatic test_reset_in_scan();
        a = 16'h00FF; b = 16'h0001; s_apx = 16'h00F0; c_spec = 4'b0000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL scan_rst_valid: got %b expected 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL scan_rst_ready: got %b expected 1", in_ready); end
        n_vec++; if (sum !== '0 || nfix !== '0 || cout !== 1'b0) begin n_err++; $display("FAIL scan_rst_outputs: got sum=%h nfix=%0d cout=%b expected 0", sum, nfix, cout); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL scan_rst_stays_idle: got %b expected 0", out_valid); end
    endtask

    // Randomized transactions issued back to back, each accept on the cycle after release
    task automatic test_random();
        logic [WIDTH-1:0] ta, tb_, ts, es;
        logic [NBLK-1:0] tc;
        logic ec;
        logic [NFW-1:0] en;
        int lat;
        for (int i = 0; i < 40; i++) begin
            ta = WIDTH'($urandom);
            tb_ = WIDTH'($urandom);
            if (i % 4 == 0) tb_ = ~ta;
            tc = NBLK'($urandom);
            ts = spec_sum(ta, tb_, tc);
            ref_model(ta, tb_, ts, tc, es, ec, en);
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rnd_in_ready[%0d]: got %b expected 1", i, in_ready); end
            send(ta, tb_, ts, tc, lat);
            n_vec++; if (lat != EXP_LAT) begin n_err++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, EXP_LAT); end
            n_vec++; if (sum !== es || cout !== ec) begin n_err++; $display("FAIL rnd_sum[%0d]: got %b_%h expected %b_%h (a=%h b=%h c=%b)", i, cout, sum, ec, es, ta, tb_, tc); end
            n_vec++; if (nfix !== en || corrected !== (en != 0)) begin n_err++; $display("FAIL rnd_nfix[%0d]: got %0d/%b expected %0d/%b", i, nfix, corrected, en, en != 0); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_in_scan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
